// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_ctrl_pkg
// Shared definitions for the mux scan sequencer: FSM state encoding,
// channel index constants and the dwell counter width.
package mux_scan_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if
// Bundle between the scan sequencer and its surroundings.
//   start : scan request (into sequencer)
//   y     : 4-to-1 mux output under test (into sequencer)
//   s1/s0 : mux select lines (from sequencer)
//   busy  : scan in progress (from sequencer)
//   done  : one-cycle completion pulse (from sequencer)
//   word  : last completed scan, word[k] = channel k (from sequencer)
// master = requester / mux side, slave = the sequencer.
interface mux_scan_ctrl_if;
    logic       start;
    logic       y;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       done;
    logic [3:0] word;

    modport master (
        output start, y,
        input  s1, s0, busy, done, word
    );

    modport slave (
        input  start, y,
        output s1, s0, busy, done, word
    );
endinterface

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// dwell_timer
// Loadable down-counter that times how long each mux channel settles.
// Counts down to zero and sticks there; zero flags the sample cycle.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset (count cleared)
//   load     : load load_val this edge (takes priority over counting)
//   load_val : reload value
//   zero     : count is zero
module dwell_timer
    import mux_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Sequencer upstream of a 4-to-1 mux: steps {s1,s0} through channels
// 0..3, waits DWELL cycles on each, samples y, and publishes the four
// samples as word with a one-cycle done pulse. All outputs registered.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_scan_ctrl_if.slave (start, y in; s1, s0, busy, done, word out)
// Parameter DWELL (1..15): cycles per channel before y is sampled.
// Build option: define MUX_SCAN_CONT_EN for continuous mode, where the
// sequencer restarts a scan on every done without needing start.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 2
)(
    input  logic           clk,
    input  logic           rst_n,
    mux_scan_ctrl_if.slave bus
);

`ifdef MUX_SCAN_CONT_EN
    localparam bit CONT_EN = 1'b1;
`else
    localparam bit CONT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t     state;
    logic [1:0] sel;
    logic [3:0] shadow;
    logic [3:0] word_q;
    logic       busy_q;
    logic       done_q;
    logic       zero;
    logic       load;

    // Reload on scan launch and on every channel advance; the last channel
    // only reloads when the scan rolls straight into the next one.
    assign load = ((state == ST_IDLE) && bus.start) ||
                  ((state == ST_SCAN) && zero && ((sel != CH_D) || CONT_EN));

    dwell_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (RELOAD),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sel    <= CH_A;
            shadow <= '0;
            word_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state  <= ST_SCAN;
                        busy_q <= 1'b1;
                        sel    <= CH_A;
                        shadow <= '0;
                    end
                end
                ST_SCAN: begin
                    if (zero) begin
                        shadow[sel] <= bus.y;
                        if (sel != CH_D) begin
                            sel <= sel + 2'd1;
                        end else begin
                            // shadow[3] is not yet written, so take y directly
                            word_q <= {bus.y, shadow[2:0]};
                            done_q <= 1'b1;
                            sel    <= CH_A;
                            if (!CONT_EN) begin
                                busy_q <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.s1   = sel[1];
    assign bus.s0   = sel[0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.word = word_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
// Directed bench: three sequencers (DWELL = 1, 2, 3) each driving a
// behavioural 4-to-1 mux whose inputs come from ch[3:0] = {d,c,b,a}.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] ch = 4'b0000;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl_if if1 ();
    mux_scan_ctrl_if if2 ();
    mux_scan_ctrl_if if3 ();

    logic [1:0] idx1, idx2, idx3;
    assign idx1   = {if1.s1, if1.s0};
    assign idx2   = {if2.s1, if2.s0};
    assign idx3   = {if3.s1, if3.s0};
    assign if1.y  = ch[idx1];
    assign if2.y  = ch[idx2];
    assign if3.y  = ch[idx3];

    mux_scan_ctrl #(.DWELL(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mux_scan_ctrl #(.DWELL(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    mux_scan_ctrl #(.DWELL(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    // {s1,s0,busy,done,word}
    function automatic logic [7:0] st1();
        return {if1.s1, if1.s0, if1.busy, if1.done, if1.word};
    endfunction
    function automatic logic [7:0] st2();
        return {if2.s1, if2.s0, if2.busy, if2.done, if2.word};
    endfunction
    function automatic logic [7:0] st3();
        return {if3.s1, if3.s0, if3.busy, if3.done, if3.word};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (st1() !== 8'h00) begin n_fail++; $display("FAIL reset_d1: got %b want 00000000", st1()); end
        n_chk++; if (st2() !== 8'h00) begin n_fail++; $display("FAIL reset_d2: got %b want 00000000", st2()); end
        n_chk++; if (st3() !== 8'h00) begin n_fail++; $display("FAIL reset_d3: got %b want 00000000", st3()); end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if (st2() !== 8'h00) begin n_fail++; $display("FAIL reset_release: got %b want 00000000", st2()); end
    endtask

`ifndef MUX_SCAN_CONT_EN
    task automatic test_single_scan();
        int busy_cycles = 0;
        ch = 4'b1010;
        @(negedge clk); if2.start = 1'b1;
        @(posedge clk);                       // E0
        for (int j = 0; j <= 9; j++) begin
            @(negedge clk);                   // state after E0+j
            if2.start = 1'b0;
            if (if2.busy === 1'b1) busy_cycles++;
            if (j < 8) begin
                n_chk++;
                if ({if2.busy, if2.done} !== 2'b10) begin
                    n_fail++; $display("FAIL single_scan_run j=%0d: busy,done=%b want 10", j, {if2.busy, if2.done});
                end
            end else begin
                n_chk++;
                if ({if2.busy, if2.done, if2.word} !== {1'b0, (j == 8), 4'b1010}) begin
                    n_fail++; $display("FAIL single_scan_end j=%0d: busy,done,word=%b want 0%0d1010", j, {if2.busy, if2.done, if2.word}, (j == 8));
                end
            end
        end
        n_chk++;
        if (busy_cycles != 8) begin n_fail++; $display("FAIL single_scan_busy_len: got %0d want 8", busy_cycles); end
    endtask

    task automatic test_select_seq();
        logic [1:0] exp_sel;
        ch = 4'b0000;
        @(negedge clk); if3.start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 13; j++) begin
            @(negedge clk);
            if3.start = 1'b0;
            exp_sel = (j < 12) ? 2'(j / 3) : 2'd0;
            n_chk++;
            if ({if3.s1, if3.s0} !== exp_sel) begin
                n_fail++; $display("FAIL select_seq j=%0d: sel=%b want %b", j, {if3.s1, if3.s0}, exp_sel);
            end
        end
        n_chk++;
        if (if3.busy !== 1'b0) begin n_fail++; $display("FAIL select_seq_idle: busy=%b want 0", if3.busy); end
    endtask

    task automatic test_back_to_back();
        int dones_a = 0;
        int dones_b = 0;
        ch = 4'b1111;
        @(negedge clk); if2.start = 1'b1;
        @(posedge clk);                       // E0
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            if (j == 9) if2.start = 1'b0;     // held through the first done cycle
            if (if2.done === 1'b1) begin
                if (j <= 8) dones_a++; else dones_b++;
            end
            if (j == 8) begin
                n_chk++;
                if ({if2.done, if2.word} !== 5'b11111) begin
                    n_fail++; $display("FAIL b2b_first: done,word=%b want 11111", {if2.done, if2.word});
                end
            end
            if (j == 9) begin
                n_chk++;
                if ({if2.busy, if2.done, if2.s1, if2.s0} !== 4'b1000) begin
                    n_fail++; $display("FAIL b2b_restart: busy,done,sel=%b want 1000", {if2.busy, if2.done, if2.s1, if2.s0});
                end
            end
            if (j == 17) begin
                n_chk++;
                if ({if2.busy, if2.done, if2.word} !== 6'b011111) begin
                    n_fail++; $display("FAIL b2b_second: busy,done,word=%b want 011111", {if2.busy, if2.done, if2.word});
                end
            end
        end
        n_chk++; if (dones_a != 1) begin n_fail++; $display("FAIL b2b_done_count_1: got %0d want 1", dones_a); end
        n_chk++; if (dones_b != 1) begin n_fail++; $display("FAIL b2b_done_count_2: got %0d want 1", dones_b); end
        n_chk++; if (if2.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b want 0", if2.busy); end
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        ch = 4'b0110;
        @(negedge clk); if2.start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            if2.start = 1'b0;
        end
        n_chk++;
        if (if2.busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre: busy=%b want 1", if2.busy); end
        rst_n = 1'b0;                         // 5th cycle of the scan
        #1;
        n_chk++;
        if (st2() !== 8'h00) begin n_fail++; $display("FAIL reset_mid_async: got %b want 00000000", st2()); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (if2.done !== 1'b0 || if2.busy !== 1'b0) stray++;
        end
        n_chk++;
        if (stray != 0 || if2.word !== 4'b0000) begin
            n_fail++; $display("FAIL reset_mid_after: stray=%0d word=%b want 0 0000", stray, if2.word);
        end
    endtask

    task automatic test_dwell1();
        ch = 4'b0101;                         // a=1 b=0 c=1 d=0
        @(negedge clk); if1.start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            if1.start = 1'b0;
            if (j < 4) begin
                n_chk++;
                if ({if1.busy, if1.done, if1.s1, if1.s0} !== {2'b10, 2'(j)}) begin
                    n_fail++; $display("FAIL dwell1_run j=%0d: busy,done,sel=%b want 10%b", j, {if1.busy, if1.done, if1.s1, if1.s0}, 2'(j));
                end
            end else begin
                n_chk++;
                if ({if1.busy, if1.done, if1.word} !== {1'b0, (j == 4), 4'b0101}) begin
                    n_fail++; $display("FAIL dwell1_end j=%0d: busy,done,word=%b want 0%0d0101", j, {if1.busy, if1.done, if1.word}, (j == 4));
                end
            end
        end
    endtask
`else
    task automatic test_continuous();
        logic [3:0] exp_word;
        ch = 4'b1010;
        @(negedge clk); if2.start = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= 25; j++) begin
            @(negedge clk);
            if2.start = 1'b0;
            if (j == 8)  ch[3] = 1'b0;
            if (j == 16) ch[3] = 1'b1;
            n_chk++;
            if ({if2.busy, if2.done} !== {1'b1, (j == 8 || j == 16 || j == 24)}) begin
                n_fail++; $display("FAIL cont_run j=%0d: busy,done=%b", j, {if2.busy, if2.done});
            end
            if (j == 8 || j == 16 || j == 24) begin
                exp_word = (j == 16) ? 4'b0010 : 4'b1010;
                n_chk++;
                if (if2.word !== exp_word) begin
                    n_fail++; $display("FAIL cont_word j=%0d: got %b want %b", j, if2.word, exp_word);
                end
            end
        end
    endtask
`endif

    initial begin
        if1.start = 1'b0;
        if2.start = 1'b0;
        if3.start = 1'b0;
        test_reset();
`ifndef MUX_SCAN_CONT_EN
        test_single_scan();
        test_select_seq();
        test_back_to_back();
        test_reset_mid();
        test_dwell1();
`else
        test_continuous();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
